// File: rtl/hazard_fwd_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_fwd_ctrl_pkg
//   Shared definitions for the hazard / forwarding controller:
//   - default register-specifier width and shadow depth
//   - in-flight destination slot record and its bubble value
//   - forwarding source encoding plus a helper that applies
//     younger-producer priority
// -----------------------------------------------------------------------------
package hazard_fwd_ctrl_pkg;

  localparam int HFC_REG_W  = 3;
  localparam int HFC_PIPE_D = 2;

  // Shadow slot indices: 0 tracks the instruction in EX, 1 the one in MEM.
  localparam int SLOT_EX  = 0;
  localparam int SLOT_MEM = 1;

  typedef struct packed {
    logic                 vld;      // non-bubble instruction that writes the RF
    logic [HFC_REG_W-1:0] wr_reg;   // destination specifier
    logic                 is_load;  // result only available after MEM
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '{vld: 1'b0, wr_reg: '0, is_load: 1'b0};

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_EX   = 2'd1,
    FWD_MEM  = 2'd2
  } fwd_src_e;

  // The EX-slot producer is younger than the MEM-slot one, so it wins.
  function automatic fwd_src_e fwd_pick(input logic ex_hit, input logic mem_hit);
    if (ex_hit)       return FWD_EX;
    else if (mem_hit) return FWD_MEM;
    else              return FWD_NONE;
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_dst_match.sv
// -----------------------------------------------------------------------------
// hazard_fwd_ctrl_dst_match
//   Compares one in-flight destination slot against one source operand of
//   the instruction in ID.
// Ports
//   i_vld     slot holds a real register-writing instruction
//   i_wr_reg  slot destination specifier
//   i_rd_reg  ID source specifier
//   i_use     ID instruction actually reads this operand
//   o_match   operand depends on the slot's result
// -----------------------------------------------------------------------------
module hazard_fwd_ctrl_dst_match #(
  parameter int REG_W = 3
) (
  input  logic             i_vld,
  input  logic [REG_W-1:0] i_wr_reg,
  input  logic [REG_W-1:0] i_rd_reg,
  input  logic             i_use,
  output logic             o_match
);

  // r0 is an ordinary register here: no special casing of specifier 0.
  assign o_match = i_use & i_vld & (i_wr_reg == i_rd_reg);

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_fwd_ctrl
//   Stall / forward control for the ID/EX latch. Shadows the destinations of
//   the instructions in EX and MEM, raises a one-bubble load-use stall and
//   produces registered per-operand forward selects that line up with the
//   instruction once it reaches EX.
// Ports
//   clk, rst        clock, synchronous active-high reset
//   id_rd_reg_1/2   Rs / Rt specifiers of the ID instruction
//   id_uses_Rs      ID instruction reads Rs
//   id_has_Rt       ID instruction reads Rt
//   id_wr_en        ID instruction writes the register file
//   id_wr_reg       ID destination specifier
//   id_is_load      ID instruction is a load
//   mem_stall_n     low: whole pipeline frozen
//   take_new_PC     taken branch/jump: squash ID
//   hazard_stall_n  low: hold ID, bubble into EX (combinational)
//   ex_fwd_Rs/Rt    EX operand from EX/MEM result (registered)
//   mem_fwd_Rs/Rt   EX operand from MEM/WB result (registered)
//   err             some input is X/Z
// -----------------------------------------------------------------------------
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int REG_W  = HFC_REG_W,
  parameter int PIPE_D = HFC_PIPE_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rd_reg_1,
  input  logic [REG_W-1:0] id_rd_reg_2,
  input  logic             id_uses_Rs,
  input  logic             id_has_Rt,
  input  logic             id_wr_en,
  input  logic [REG_W-1:0] id_wr_reg,
  input  logic             id_is_load,
  input  logic             mem_stall_n,
  input  logic             take_new_PC,
  output logic             hazard_stall_n,
  output logic             ex_fwd_Rs,
  output logic             ex_fwd_Rt,
  output logic             mem_fwd_Rs,
  output logic             mem_fwd_Rt,
  output logic             err
);

  slot_t    r_slot [PIPE_D];

  logic     r_ex_fwd_rs_p1;
  logic     r_ex_fwd_rt_p1;
  logic     r_mem_fwd_rs_p1;
  logic     r_mem_fwd_rt_p1;

  logic     w_match_ex_rs;
  logic     w_match_ex_rt;
  logic     w_match_mem_rs;
  logic     w_match_mem_rt;
  logic     w_load_use;
  logic     w_issue;
  logic     w_adv_en;
  fwd_src_e w_src_rs;
  fwd_src_e w_src_rt;

  // ---- ID stage: dependency compare against the EX and MEM shadows ----
  hazard_fwd_ctrl_dst_match #(.REG_W(REG_W)) u_match_ex_rs (
    .i_vld    (r_slot[SLOT_EX].vld),
    .i_wr_reg (r_slot[SLOT_EX].wr_reg),
    .i_rd_reg (id_rd_reg_1),
    .i_use    (id_uses_Rs),
    .o_match  (w_match_ex_rs)
  );

  hazard_fwd_ctrl_dst_match #(.REG_W(REG_W)) u_match_ex_rt (
    .i_vld    (r_slot[SLOT_EX].vld),
    .i_wr_reg (r_slot[SLOT_EX].wr_reg),
    .i_rd_reg (id_rd_reg_2),
    .i_use    (id_has_Rt),
    .o_match  (w_match_ex_rt)
  );

  hazard_fwd_ctrl_dst_match #(.REG_W(REG_W)) u_match_mem_rs (
    .i_vld    (r_slot[SLOT_MEM].vld),
    .i_wr_reg (r_slot[SLOT_MEM].wr_reg),
    .i_rd_reg (id_rd_reg_1),
    .i_use    (id_uses_Rs),
    .o_match  (w_match_mem_rs)
  );

  hazard_fwd_ctrl_dst_match #(.REG_W(REG_W)) u_match_mem_rt (
    .i_vld    (r_slot[SLOT_MEM].vld),
    .i_wr_reg (r_slot[SLOT_MEM].wr_reg),
    .i_rd_reg (id_rd_reg_2),
    .i_use    (id_has_Rt),
    .o_match  (w_match_mem_rt)
  );

  // A load in EX cannot feed ID next cycle; a squashed ID has nothing to protect.
  assign w_load_use     = r_slot[SLOT_EX].is_load & (w_match_ex_rs | w_match_ex_rt);
  assign hazard_stall_n = take_new_PC | ~w_load_use;
  assign w_issue        = hazard_stall_n & ~take_new_PC;

  assign w_src_rs = fwd_pick(w_match_ex_rs, w_match_mem_rs);
  assign w_src_rt = fwd_pick(w_match_ex_rt, w_match_mem_rt);

  // Reset must land even while memory holds the pipeline.
  assign w_adv_en = mem_stall_n | rst;

  // ---- ID -> EX boundary: shadow advance and forward-select registers ----
  always_ff @(posedge clk) begin
    // Destination specifiers are data: they move but are never reset; vld
    // alone decides whether a slot's specifier means anything.
    if (w_adv_en) begin
      r_slot[SLOT_MEM].wr_reg <= r_slot[SLOT_EX].wr_reg;
      r_slot[SLOT_EX].wr_reg  <= w_issue ? id_wr_reg : SLOT_BUBBLE.wr_reg;
    end

    if (rst) begin
      r_slot[SLOT_EX].vld      <= 1'b0;
      r_slot[SLOT_EX].is_load  <= 1'b0;
      r_slot[SLOT_MEM].vld     <= 1'b0;
      r_slot[SLOT_MEM].is_load <= 1'b0;
      r_ex_fwd_rs_p1           <= 1'b0;
      r_ex_fwd_rt_p1           <= 1'b0;
      r_mem_fwd_rs_p1          <= 1'b0;
      r_mem_fwd_rt_p1          <= 1'b0;
    end else if (mem_stall_n) begin
      r_slot[SLOT_MEM].vld     <= r_slot[SLOT_EX].vld;
      r_slot[SLOT_MEM].is_load <= r_slot[SLOT_EX].is_load;
      if (w_issue) begin
        r_slot[SLOT_EX].vld     <= id_wr_en;
        r_slot[SLOT_EX].is_load <= id_is_load;
        r_ex_fwd_rs_p1          <= (w_src_rs == FWD_EX);
        r_ex_fwd_rt_p1          <= (w_src_rt == FWD_EX);
        r_mem_fwd_rs_p1         <= (w_src_rs == FWD_MEM);
        r_mem_fwd_rt_p1         <= (w_src_rt == FWD_MEM);
      end else begin
        // Bubble enters EX: it produces nothing and consumes nothing.
        r_slot[SLOT_EX].vld     <= SLOT_BUBBLE.vld;
        r_slot[SLOT_EX].is_load <= SLOT_BUBBLE.is_load;
        r_ex_fwd_rs_p1          <= 1'b0;
        r_ex_fwd_rt_p1          <= 1'b0;
        r_mem_fwd_rs_p1         <= 1'b0;
        r_mem_fwd_rt_p1         <= 1'b0;
      end
    end
  end

  assign ex_fwd_Rs  = r_ex_fwd_rs_p1;
  assign ex_fwd_Rt  = r_ex_fwd_rt_p1;
  assign mem_fwd_Rs = r_mem_fwd_rs_p1;
  assign mem_fwd_Rt = r_mem_fwd_rt_p1;

  // Reduction XOR turns any X/Z bit into X.
  assign err = ((^{rst, id_rd_reg_1, id_rd_reg_2, id_uses_Rs, id_has_Rt, id_wr_en,
                   id_wr_reg, id_is_load, mem_stall_n, take_new_PC}) === 1'bx);

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_fwd_ctrl
//   Self-checking bench: directed instruction sequences followed by random
//   traffic, all compared against an instruction-level pipeline model.
// -----------------------------------------------------------------------------
module tb_hazard_fwd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] id_rd_reg_1, id_rd_reg_2, id_wr_reg;
  logic       id_uses_Rs, id_has_Rt, id_wr_en, id_is_load;
  logic       mem_stall_n, take_new_PC;
  logic       hazard_stall_n, ex_fwd_Rs, ex_fwd_Rt, mem_fwd_Rs, mem_fwd_Rt, err;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_fwd_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .id_rd_reg_1    (id_rd_reg_1),
    .id_rd_reg_2    (id_rd_reg_2),
    .id_uses_Rs     (id_uses_Rs),
    .id_has_Rt      (id_has_Rt),
    .id_wr_en       (id_wr_en),
    .id_wr_reg      (id_wr_reg),
    .id_is_load     (id_is_load),
    .mem_stall_n    (mem_stall_n),
    .take_new_PC    (take_new_PC),
    .hazard_stall_n (hazard_stall_n),
    .ex_fwd_Rs      (ex_fwd_Rs),
    .ex_fwd_Rt      (ex_fwd_Rt),
    .mem_fwd_Rs     (mem_fwd_Rs),
    .mem_fwd_Rt     (mem_fwd_Rt),
    .err            (err)
  );

  task automatic check_eq(input string tag, input logic obs, input logic exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // In-flight instructions, youngest first: age 0 = in EX, age 1 = in MEM.
  typedef struct {
    bit       writes;
    bit [2:0] dst;
    bit       load;
  } instr_t;

  instr_t inflight [2];
  bit     e_ex_rs, e_ex_rt, e_mem_rs, e_mem_rt;

  // Age of the youngest in-flight producer of register r, or -1 if none.
  function automatic int producer_age(input bit [2:0] r, input bit used);
    if (!used) return -1;
    for (int a = 0; a < 2; a++)
      if (inflight[a].writes && inflight[a].dst == r) return a;
    return -1;
  endfunction

  function automatic bit model_stall();
    if (take_new_PC) return 1'b0;
    return inflight[0].load &&
           (producer_age(id_rd_reg_1, id_uses_Rs) == 0 ||
            producer_age(id_rd_reg_2, id_has_Rt) == 0);
  endfunction

  task automatic model_clock(input bit stall);
    int s1, s2;
    instr_t nop;
    bit enter;
    nop = '{writes: 1'b0, dst: 3'd0, load: 1'b0};
    if (rst) begin
      inflight[0] = nop;
      inflight[1] = nop;
      {e_ex_rs, e_ex_rt, e_mem_rs, e_mem_rt} = 4'b0;
    end else if (mem_stall_n) begin
      enter = !take_new_PC && !stall;
      s1 = producer_age(id_rd_reg_1, id_uses_Rs);
      s2 = producer_age(id_rd_reg_2, id_has_Rt);
      e_ex_rs  = enter && s1 == 0;
      e_ex_rt  = enter && s2 == 0;
      e_mem_rs = enter && s1 == 1;
      e_mem_rt = enter && s2 == 1;
      inflight[1] = inflight[0];
      inflight[0] = enter ? '{writes: id_wr_en, dst: id_wr_reg, load: id_is_load} : nop;
    end
  endtask

  // One clock: drive ID/control inputs, check the combinational stall,
  // clock, then check the registered selects.
  task automatic step(input logic [2:0] rs, input logic urs, input logic [2:0] rt,
                      input logic urt, input logic wen, input logic [2:0] wd,
                      input logic ld, input logic ms, input logic tk, input logic rr,
                      output logic stall_obs);
    bit st;
    @(negedge clk);
    id_rd_reg_1 = rs;  id_uses_Rs = urs;
    id_rd_reg_2 = rt;  id_has_Rt  = urt;
    id_wr_en    = wen; id_wr_reg  = wd; id_is_load = ld;
    mem_stall_n = ms;  take_new_PC = tk; rst = rr;
    #1;
    st = model_stall();
    stall_obs = hazard_stall_n;
    check_eq("hazard_stall_n", hazard_stall_n, !st);
    check_eq("err", err, 1'b0);
    @(posedge clk);
    model_clock(st);
    #1;
    check_eq("ex_fwd_Rs",  ex_fwd_Rs,  e_ex_rs);
    check_eq("ex_fwd_Rt",  ex_fwd_Rt,  e_ex_rt);
    check_eq("mem_fwd_Rs", mem_fwd_Rs, e_mem_rs);
    check_eq("mem_fwd_Rt", mem_fwd_Rt, e_mem_rt);
  endtask

  // Shorthands: normal-flow instruction, and a nop.
  task automatic ins(input logic [2:0] rs, input logic urs, input logic [2:0] rt,
                     input logic urt, input logic wen, input logic [2:0] wd,
                     input logic ld, output logic so);
    step(rs, urs, rt, urt, wen, wd, ld, 1'b1, 1'b0, 1'b0, so);
  endtask

  logic so;

  initial begin
    inflight[0] = '{writes: 1'b0, dst: 3'd0, load: 1'b0};
    inflight[1] = inflight[0];
    {e_ex_rs, e_ex_rt, e_mem_rs, e_mem_rt} = 4'b0;
    rst = 1'b1; mem_stall_n = 1'b1; take_new_PC = 1'b0;
    id_rd_reg_1 = '0; id_rd_reg_2 = '0; id_wr_reg = '0;
    id_uses_Rs = 0; id_has_Rt = 0; id_wr_en = 0; id_is_load = 0;

    // Reset, with noisy control inputs that reset must override.
    step(3'd1, 1, 3'd2, 1, 1, 3'd1, 1, 1'b0, 1'b1, 1'b1, so);
    step(3'd1, 1, 3'd2, 1, 1, 3'd1, 1, 1'b1, 1'b0, 1'b1, so);
    check_eq("rst_stall_n", so, 1'b1);
    check_eq("rst_ex_fwd_Rs", ex_fwd_Rs, 1'b0);
    check_eq("rst_mem_fwd_Rt", mem_fwd_Rt, 1'b0);

    // 1: add r3 ; add r1,r3,r3 -> EX forward on both operands.
    ins(3'd0, 0, 3'd0, 0, 1, 3'd3, 0, so);
    ins(3'd3, 1, 3'd3, 1, 1, 3'd1, 0, so);
    check_eq("c1_stall_n", so, 1'b1);
    check_eq("c1_ex_rs", ex_fwd_Rs, 1'b1);
    check_eq("c1_ex_rt", ex_fwd_Rt, 1'b1);
    check_eq("c1_mem_rs", mem_fwd_Rs, 1'b0);

    // 2: add r3 ; nop ; sub r2,r3,r4 -> MEM forward on Rs.
    ins(3'd0, 0, 3'd0, 0, 1, 3'd3, 0, so);
    ins(3'd0, 0, 3'd0, 0, 0, 3'd0, 0, so);
    ins(3'd3, 1, 3'd4, 1, 1, 3'd2, 0, so);
    check_eq("c2_stall_n", so, 1'b1);
    check_eq("c2_mem_rs", mem_fwd_Rs, 1'b1);
    check_eq("c2_ex_rs", ex_fwd_Rs, 1'b0);

    // 3: ld r5 ; add r6,r5,r0 -> one bubble, then MEM forward.
    ins(3'd0, 0, 3'd0, 0, 1, 3'd5, 1, so);
    ins(3'd5, 1, 3'd0, 1, 1, 3'd6, 0, so);
    check_eq("c3_stall", so, 1'b0);
    check_eq("c3_bubble_ex_rs", ex_fwd_Rs, 1'b0);
    ins(3'd5, 1, 3'd0, 1, 1, 3'd6, 0, so);
    check_eq("c3_no_2nd_stall", so, 1'b1);
    check_eq("c3_mem_rs", mem_fwd_Rs, 1'b1);
    check_eq("c3_ex_rs", ex_fwd_Rs, 1'b0);

    // 4: add r2 ; add r2 ; use r2 -> younger producer wins.
    ins(3'd0, 0, 3'd0, 0, 1, 3'd2, 0, so);
    ins(3'd0, 0, 3'd0, 0, 1, 3'd2, 0, so);
    ins(3'd2, 1, 3'd7, 0, 0, 3'd0, 0, so);
    check_eq("c4_ex_rs", ex_fwd_Rs, 1'b1);
    check_eq("c4_mem_rs", mem_fwd_Rs, 1'b0);

    // 5: ld r5 in EX, ID uses r5, branch taken -> no stall, bubble.
    ins(3'd0, 0, 3'd0, 0, 1, 3'd5, 1, so);
    step(3'd5, 1, 3'd5, 1, 1, 3'd1, 0, 1'b1, 1'b1, 1'b0, so);
    check_eq("c5_stall_n", so, 1'b1);
    check_eq("c5_ex_rs", ex_fwd_Rs, 1'b0);
    check_eq("c5_mem_rt", mem_fwd_Rt, 1'b0);
    ins(3'd5, 1, 3'd0, 0, 0, 3'd0, 0, so);   // load now in MEM, EX is bubble
    check_eq("c5_after_mem_rs", mem_fwd_Rs, 1'b1);

    // 6a: case 1 with a 3-cycle freeze (also with a pending squash) in between.
    ins(3'd0, 0, 3'd0, 0, 1, 3'd3, 0, so);
    for (int k = 0; k < 3; k++)
      step(3'd3, 1, 3'd3, 1, 1, 3'd1, 0, 1'b0, (k == 1), 1'b0, so);
    check_eq("c6_frozen_ex_rs", ex_fwd_Rs, 1'b0);
    ins(3'd3, 1, 3'd3, 1, 1, 3'd1, 0, so);
    check_eq("c6_resume_ex_rs", ex_fwd_Rs, 1'b1);
    check_eq("c6_resume_ex_rt", ex_fwd_Rt, 1'b1);

    // 6b: reset during a load-use stall.
    ins(3'd0, 0, 3'd0, 0, 1, 3'd5, 1, so);
    step(3'd5, 1, 3'd0, 1, 1, 3'd6, 0, 1'b1, 1'b0, 1'b1, so);
    check_eq("c6_rst_cycle_stall", so, 1'b0);
    ins(3'd5, 1, 3'd0, 1, 1, 3'd6, 0, so);
    check_eq("c6_after_rst_stall_n", so, 1'b1);
    check_eq("c6_after_rst_mem_rs", mem_fwd_Rs, 1'b0);

    // Random traffic over a small register window to force frequent hits.
    for (int i = 0; i < 400; i++) begin
      step(3'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
           3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 4) != 0), 3'($urandom_range(0, 3)),
           1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 6) != 0), 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 40) == 0), so);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
